// File: rtl/redmule_pkg.sv
`default_nettype none
// ============================================================================
// Module  : redmule_pkg
// Purpose : Shared types for the RedMulE tile sequencer: the tile descriptor
//           handed to the streamer/engine and the sequencer state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package redmule_pkg;

  // Width of each descriptor index field; the sequencer's IterWidth must match.
  localparam int unsigned IterW = 16;

  typedef struct packed {
    logic [IterW-1:0] m_idx;
    logic [IterW-1:0] n_idx;
    logic [IterW-1:0] k_idx;
    logic             k_last;
    logic             last;
  } tile_desc_t;

  typedef logic [2:0] tile_seq_state_e;

  localparam tile_seq_state_e IDLE  = 3'd0;
  localparam tile_seq_state_e PRIME = 3'd1;
  localparam tile_seq_state_e ISSUE = 3'd2;
  localparam tile_seq_state_e DRAIN = 3'd3;
  localparam tile_seq_state_e DONE  = 3'd4;
  localparam tile_seq_state_e ERR   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/redmule_nested_counter.sv
`default_nettype none
// ============================================================================
// Module  : redmule_nested_counter
// Purpose : Three-level wrap counter. Level 0 is innermost; a level advances
//           only when every lower level is at its maximum.
// Ports   : clk_i, rst_i (sync, active-high)
//           en_i      advance by one position
//           clear_i   return all indices to 0 (wins over en_i)
//           max_i[3]  per-level maximum index (count - 1)
//           idx_o[3]  current indices
//           wrap_o[3] level i and all lower levels are at max
//           all_max_o every level at max (final position)
// Revision: 1.0 - initial release
// ============================================================================
module redmule_nested_counter #(
  parameter int unsigned Width = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [2:0][Width-1:0] max_i,
  output logic [2:0][Width-1:0] idx_o,
  output logic [2:0]            wrap_o,
  output logic                  all_max_o
);

  logic [2:0][Width-1:0] idx_q, idx_d;
  logic [2:0]            at_max;
  logic [2:0]            step;

  for (genvar i = 0; i < 3; i++) begin : g_level
    assign at_max[i] = (idx_q[i] == max_i[i]);
    assign wrap_o[i] = &at_max[i:0];
  end

  // A level steps when enabled and every lower level is about to wrap.
  assign step      = {en_i & wrap_o[1], en_i & wrap_o[0], en_i};
  assign all_max_o = wrap_o[2];
  assign idx_o     = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (step[i]) begin
          idx_d[i] = at_max[i] ? '0 : idx_q[i] + Width'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idx_q <= '0;
    else       idx_q <= idx_d;
  end

endmodule
`default_nettype wire

// File: rtl/redmule_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : redmule_tile_sequencer
// Purpose : Walks the M x N x K tile loop (k innermost) after a job start and
//           issues one tile descriptor per compute step over valid/ready.
//           Tracks W-tile load completion and outstanding Z stores, and pulses
//           done once every tile is issued and every Z store acknowledged.
// Ports   : clk_i, rst_i (sync, active-high), clear_i (soft abort = reset)
//           first_load_i (rising edge starts), m/n/k_iters_i (tile counts)
//           w_load_done_i, tile_valid_o/tile_ready_i/tile_desc_o,
//           z_store_done_i, w_loaded_o, busy_o, done_o, cfg_err_o,
//           stall_cycles_o
// Config  : REDMULE_TILE_SEQ_PERF_EN enables the stall-cycle counter;
//           otherwise stall_cycles_o is constant 0.
// Note    : IterWidth must equal redmule_pkg::IterW.
// Revision: 1.0 - initial release
// ============================================================================
module redmule_tile_sequencer
  import redmule_pkg::*;
#(
  parameter int unsigned IterWidth      = IterW,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned PerfCntWidth   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    first_load_i,
  input  logic [IterWidth-1:0]    m_iters_i,
  input  logic [IterWidth-1:0]    n_iters_i,
  input  logic [IterWidth-1:0]    k_iters_i,
  input  logic                    w_load_done_i,
  output logic                    tile_valid_o,
  input  logic                    tile_ready_i,
  output tile_desc_t              tile_desc_o,
  input  logic                    z_store_done_i,
  output logic                    w_loaded_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    cfg_err_o,
  output logic [PerfCntWidth-1:0] stall_cycles_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding) + 1;

  tile_seq_state_e      state_q, state_d;
  logic                 first_load_q, first_load_d;
  logic                 w_loaded_q, w_loaded_d;
  logic [IterWidth-1:0] m_max_q, m_max_d, n_max_q, n_max_d, k_max_q, k_max_d;
  logic [OutW-1:0]      outst_q, outst_d;

  logic                        srst, start, valid, accept, inc, dec;
  logic [2:0][IterWidth-1:0]   cnt_idx;
  logic [2:0]                  cnt_wrap;
  logic                        cnt_all_max;
  logic                        unused_wrap;

  // clear_i behaves exactly like reset.
  assign srst   = rst_i | clear_i;
  assign start  = (state_q == IDLE) && first_load_i && !first_load_q;
  assign valid  = (state_q == ISSUE) && (outst_q != OutW'(MaxOutstanding));
  assign accept = valid && tile_ready_i;

  // Only k_last completes a Z tile; a store ack with nothing in flight is dropped.
  assign inc = accept && cnt_wrap[0];
  assign dec = z_store_done_i && (outst_q != '0);

  assign unused_wrap = ^cnt_wrap[2:1];

  redmule_nested_counter #(
    .Width (IterWidth)
  ) u_cnt (
    .clk_i     (clk_i),
    .rst_i     (srst),
    .en_i      (accept),
    .clear_i   (start),
    .max_i     ({m_max_q, n_max_q, k_max_q}),
    .idx_o     (cnt_idx),
    .wrap_o    (cnt_wrap),
    .all_max_o (cnt_all_max)
  );

  always_comb begin
    state_d      = state_q;
    first_load_d = first_load_i;
    w_loaded_d   = w_loaded_q;
    m_max_d      = m_max_q;
    n_max_d      = n_max_q;
    k_max_d      = k_max_q;
    outst_d      = outst_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_max_d = m_iters_i - IterWidth'(1);
          n_max_d = n_iters_i - IterWidth'(1);
          k_max_d = k_iters_i - IterWidth'(1);
          if ((m_iters_i == '0) || (n_iters_i == '0) || (k_iters_i == '0)) state_d = ERR;
          else                                                              state_d = PRIME;
        end
      end
      PRIME: begin
        if (w_load_done_i) begin
          w_loaded_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (accept && cnt_all_max) state_d = DRAIN;
      end
      DRAIN: begin
        if (outst_q == '0) state_d = DONE;
      end
      DONE, ERR: begin
        w_loaded_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (inc && !dec)      outst_d = outst_q + OutW'(1);
    else if (!inc && dec) outst_d = outst_q - OutW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      state_q      <= IDLE;
      first_load_q <= 1'b0;
      w_loaded_q   <= 1'b0;
      m_max_q      <= '0;
      n_max_q      <= '0;
      k_max_q      <= '0;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      first_load_q <= first_load_d;
      w_loaded_q   <= w_loaded_d;
      m_max_q      <= m_max_d;
      n_max_q      <= n_max_d;
      k_max_q      <= k_max_d;
      outst_q      <= outst_d;
    end
  end

  // Descriptor is forced to zero outside ISSUE so idle outputs stay quiet
  // (the reset max values would otherwise flag k_last/last).
  always_comb begin
    tile_desc_o = '0;
    if (state_q == ISSUE) begin
      tile_desc_o.m_idx  = cnt_idx[2];
      tile_desc_o.n_idx  = cnt_idx[1];
      tile_desc_o.k_idx  = cnt_idx[0];
      tile_desc_o.k_last = cnt_wrap[0];
      tile_desc_o.last   = cnt_all_max;
    end
  end

  assign tile_valid_o = valid;
  assign w_loaded_o   = w_loaded_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE) || (state_q == ERR);
  assign cfg_err_o    = (state_q == ERR);

`ifdef REDMULE_TILE_SEQ_PERF_EN
  logic [PerfCntWidth-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start)                                          stall_d = '0;
    else if (valid && !tile_ready_i && (stall_q != '1)) stall_d = stall_q + PerfCntWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (srst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = {PerfCntWidth{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_redmule_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_redmule_tile_sequencer
// Purpose : Self-checking bench for redmule_tile_sequencer. Expected tile
//           streams come from a nested-loop model of the M x N x K walk.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_redmule_tile_sequencer;
  import redmule_pkg::*;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, clear_i = 1'b0, first_load_i = 1'b0;
  logic        w_load_done_i = 1'b0, tile_ready_i = 1'b0, z_store_done_i = 1'b0;
  logic [15:0] m_iters_i = '0, n_iters_i = '0, k_iters_i = '0;
  logic        tile_valid_o, w_loaded_o, busy_o, done_o, cfg_err_o;
  tile_desc_t  tile_desc_o;
  logic [31:0] stall_cycles_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  redmule_tile_sequencer #(
    .IterWidth(16), .MaxOutstanding(MAXO), .PerfCntWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .first_load_i(first_load_i),
    .m_iters_i(m_iters_i), .n_iters_i(n_iters_i), .k_iters_i(k_iters_i),
    .w_load_done_i(w_load_done_i), .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .tile_desc_o(tile_desc_o), .z_store_done_i(z_store_done_i), .w_loaded_o(w_loaded_o),
    .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o), .stall_cycles_o(stall_cycles_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tile_desc_t mk(input int m, input int n, input int k, input bit kl, input bit l);
    tile_desc_t d;
    d.m_idx  = 16'(m);
    d.n_idx  = 16'(n);
    d.k_idx  = 16'(k);
    d.k_last = kl;
    d.last   = l;
    return d;
  endfunction

  task automatic set_iters(input int m, input int n, input int k);
    m_iters_i = 16'(m);
    n_iters_i = 16'(n);
    k_iters_i = 16'(k);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},   64'(busy_o),       64'd0);
    chk({tag, "_valid"},  64'(tile_valid_o), 64'd0);
    chk({tag, "_wload"},  64'(w_loaded_o),   64'd0);
    chk({tag, "_done"},   64'(done_o),       64'd0);
    chk({tag, "_cfgerr"}, 64'(cfg_err_o),    64'd0);
    chk({tag, "_desc"},   64'(tile_desc_o),  64'd0);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done_o) seen = 1'b1;
      else        tick();
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  // Start, prime, then stream the job with random ready / store acks and
  // compare every cycle against the nested-loop model.
  task automatic run_job(input int m, input int n, input int k, input bit hold,
                         input int rdy_pct, input int z_pct, output int issued);
    tile_desc_t exp_q[$];
    int  idx = 0, pending = 0, stall = 0, total;
    bit  zero_prev = 1'b0, got_done = 1'b0;
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++)
        for (int ki = 0; ki < k; ki++)
          exp_q.push_back(mk(mi, ni, ki, ki == k - 1, (mi == m - 1) && (ni == n - 1) && (ki == k - 1)));
    total = exp_q.size();

    set_iters(m, n, k);
    first_load_i = 1'b1;
    tick();
    if (!hold) first_load_i = 1'b0;
    chk("prime_busy",  64'(busy_o),       64'd1);
    chk("prime_valid", 64'(tile_valid_o), 64'd0);
    chk("prime_wload", 64'(w_loaded_o),   64'd0);
    repeat ($urandom_range(2)) begin
      tick();
      chk("prime_wait_valid", 64'(tile_valid_o), 64'd0);
    end
    w_load_done_i = 1'b1;
    tick();
    w_load_done_i = 1'b0;

    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      bit exp_valid, exp_done, rdy, zd;
      exp_done  = zero_prev;
      exp_valid = (idx < total) && (pending < MAXO);
      chk("job_done",   64'(done_o),       64'(exp_done));
      chk("job_valid",  64'(tile_valid_o), 64'(exp_valid));
      chk("job_wload",  64'(w_loaded_o),   64'd1);
      chk("job_busy",   64'(busy_o),       64'd1);
      chk("job_cfgerr", 64'(cfg_err_o),    64'd0);
      if (exp_valid) chk("job_desc", 64'(tile_desc_o), 64'(exp_q[idx]));
      if (exp_done) begin
        got_done = 1'b1;
      end else begin
        zero_prev = (idx == total) && (pending == 0);
        rdy = int'($urandom_range(99)) < rdy_pct;
        zd  = (pending > 0) && (int'($urandom_range(99)) < z_pct);
        tile_ready_i   = rdy;
        z_store_done_i = zd;
        if (exp_valid && rdy) begin
          if (exp_q[idx].k_last) pending++;
          idx++;
        end
        if (zd) pending--;
        if (exp_valid && !rdy) stall++;
        tick();
      end
    end
    if (!got_done) chk("job_timeout", 64'd0, 64'd1);
    tile_ready_i   = 1'b0;
    z_store_done_i = 1'b0;
    chk("job_issued", 64'(idx), 64'(total));
`ifdef REDMULE_TILE_SEQ_PERF_EN
    chk("job_stall", 64'(stall_cycles_o), 64'(stall));
`else
    chk("job_stall", 64'(stall_cycles_o), 64'd0);
`endif
    tick();
    check_idle("job_end");
    if (hold) begin
      tick();
      chk("hold_no_restart", 64'(busy_o), 64'd0);
      first_load_i = 1'b0;
    end
    issued = idx;
  endtask

  task automatic err_job(input int m, input int n, input int k);
    set_iters(m, n, k);
    first_load_i = 1'b1;
    tick();
    first_load_i = 1'b0;
    chk("err_cfgerr", 64'(cfg_err_o),    64'd1);
    chk("err_done",   64'(done_o),       64'd1);
    chk("err_valid",  64'(tile_valid_o), 64'd0);
    tick();
    check_idle("err_end");
  endtask

  typedef struct {
    int m; int n; int k;
    bit hold; int rdy_pct;
    bit exp_err; int exp_total;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   issued;

    vecs[0] = '{1, 1, 1, 1'b0, 100, 1'b0, 1};
    vecs[1] = '{2, 2, 3, 1'b0, 100, 1'b0, 12};
    vecs[2] = '{1, 0, 3, 1'b0, 100, 1'b1, 0};
    vecs[3] = '{3, 1, 2, 1'b0, 50,  1'b0, 6};
    vecs[4] = '{0, 2, 2, 1'b0, 100, 1'b1, 0};
    vecs[5] = '{1, 3, 1, 1'b1, 70,  1'b0, 3};
    vecs[6] = '{2, 2, 2, 1'b0, 30,  1'b0, 8};
    vecs[7] = '{2, 1, 0, 1'b0, 100, 1'b1, 0};

    // Reset state
    tick();
    tick();
    check_idle("reset");
    chk("reset_stall", 64'(stall_cycles_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Table-driven jobs
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].exp_err) begin
        err_job(vecs[v].m, vecs[v].n, vecs[v].k);
      end else begin
        run_job(vecs[v].m, vecs[v].n, vecs[v].k, vecs[v].hold, vecs[v].rdy_pct, 50, issued);
        chk("vec_total", 64'(issued), 64'(vecs[v].exp_total));
      end
      tick();
    end

    // Outstanding limit: K=1 so every tile is a Z store
    set_iters(1, 6, 1);
    tile_ready_i = 1'b1;
    first_load_i = 1'b1;
    tick();
    first_load_i = 1'b0;
    w_load_done_i = 1'b1;
    tick();
    w_load_done_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lim_valid", 64'(tile_valid_o), 64'd1);
      chk("lim_desc",  64'(tile_desc_o),  64'(mk(0, i, 0, 1'b1, 1'b0)));
      tick();
    end
    chk("lim_full", 64'(tile_valid_o), 64'd0);
    tick();
    chk("lim_full2", 64'(tile_valid_o), 64'd0);
    z_store_done_i = 1'b1;
    tick();
    z_store_done_i = 1'b0;
    chk("lim_one_more", 64'(tile_valid_o), 64'd1);
    chk("lim_desc4",    64'(tile_desc_o),  64'(mk(0, 4, 0, 1'b1, 1'b0)));
    tick();
    chk("lim_full3", 64'(tile_valid_o), 64'd0);
    z_store_done_i = 1'b1;
    wait_done(40, "lim_done");
    z_store_done_i = 1'b0;
    tile_ready_i   = 1'b0;
    tick();
    check_idle("lim_end");

    // Backpressure: descriptor holds while ready is low
    set_iters(1, 1, 4);
    tile_ready_i = 1'b1;
    first_load_i = 1'b1;
    tick();
    first_load_i = 1'b0;
    w_load_done_i = 1'b1;
    tick();
    w_load_done_i = 1'b0;
    chk("bp_desc0", 64'(tile_desc_o), 64'(mk(0, 0, 0, 1'b0, 1'b0)));
    tick();
    tile_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(tile_valid_o), 64'd1);
      chk("bp_desc",  64'(tile_desc_o),  64'(mk(0, 0, 1, 1'b0, 1'b0)));
      tick();
    end
    tile_ready_i = 1'b1;
    chk("bp_desc1", 64'(tile_desc_o), 64'(mk(0, 0, 1, 1'b0, 1'b0)));
    tick();
    chk("bp_desc2", 64'(tile_desc_o), 64'(mk(0, 0, 2, 1'b0, 1'b0)));
    tick();
    chk("bp_desc3", 64'(tile_desc_o), 64'(mk(0, 0, 3, 1'b1, 1'b1)));
    tick();
    tile_ready_i = 1'b0;
    chk("bp_drain_valid", 64'(tile_valid_o), 64'd0);
    z_store_done_i = 1'b1;
    tick();
    z_store_done_i = 1'b0;
    wait_done(10, "bp_done");
`ifdef REDMULE_TILE_SEQ_PERF_EN
    chk("bp_stall", 64'(stall_cycles_o), 64'd5);
`else
    chk("bp_stall", 64'(stall_cycles_o), 64'd0);
`endif
    tick();

    // Clear mid-job with two stores outstanding
    set_iters(1, 4, 1);
    tile_ready_i = 1'b1;
    first_load_i = 1'b1;
    tick();
    first_load_i = 1'b0;
    w_load_done_i = 1'b1;
    tick();
    w_load_done_i = 1'b0;
    tick();
    tick();
    chk("clr_pre_valid", 64'(tile_valid_o), 64'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tile_ready_i = 1'b0;
    check_idle("clr");
    chk("clr_stall", 64'(stall_cycles_o), 64'd0);
    run_job(1, 1, 1, 1'b0, 100, 100, issued);
    tick();

    // Random jobs
    for (int r = 0; r < 6; r++) begin
      run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
              1'b0, 60, 40, issued);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
